// File: rtl/master_reader.sv
`default_nettype none
// ============================================================================
//  Module      : master_reader
//  Description : Read-side initiator for the slave_device message interface.
//                A start request announces a new message to the responder.
//                The block then walks addresses 0..msg_len+1 (header high
//                byte, header low byte, then the payload bytes). Returned bytes
//                are realigned against the responder's fixed read latency. The
//                16-bit header is reassembled, payload bytes are streamed out,
//                and header sequence gaps are flagged.
//  Ports       :
//    clk         in   single clock, rising edge
//    rst_l       in   asynchronous active-low reset
//    start       in   level; accepted only in IDLE
//    abort       in   synchronous stop of the current message
//    msg_len     in   payload byte count, latched when start is accepted
//    new_msg     out  one-cycle pulse announcing a message
//    ram_rd_rq   out  high while an address is being issued
//    rd_addr     out  read address
//    data_i      in   responder read data
//    hdr_o       out  reassembled header
//    hdr_valid   out  one-cycle pulse when hdr_o updates
//    byte_o      out  payload byte
//    byte_valid  out  one-cycle pulse per payload byte
//    busy        out  message in progress
//    done        out  one-cycle pulse at message completion
//    seq_err     out  sticky header sequence error
//  Revision    : 1.0 - initial release
// ============================================================================
module master_reader #(
  parameter int RD_LATENCY = 2,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] msg_len,
  output logic             new_msg,
  output logic             ram_rd_rq,
  output logic [15:0]      rd_addr,
  input  logic [7:0]       data_i,
  output logic [15:0]      hdr_o,
  output logic             hdr_valid,
  output logic [7:0]       byte_o,
  output logic             byte_valid,
  output logic             busy,
  output logic             done,
  output logic             seq_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NOTIFY = 2'd1,
    S_ISSUE  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  // Tags travelling down the capture pipeline with each issued address
  localparam logic [1:0] c_TAG_HI  = 2'd0;
  localparam logic [1:0] c_TAG_LO  = 2'd1;
  localparam logic [1:0] c_TAG_PAY = 2'd2;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len;
  logic [7:0]            r_hi;
  logic [15:0]           r_last_hdr;
  logic                  r_first;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [1:0]            r_pipe_tag [RD_LATENCY];

  logic [15:0]           w_last_addr;
  logic [1:0]            w_addr_tag;
  logic                  w_pipe_empty;
  logic                  w_exit_vld;
  logic [1:0]            w_exit_tag;
  logic [15:0]           w_new_hdr;

  assign w_last_addr  = 16'(r_len) + 16'd1;
  assign w_pipe_empty = ~|r_pipe_vld;
  // An abort in the same cycle as a pipeline exit suppresses that capture,
  // so no header/payload pulse appears after the abort cycle.
  assign w_exit_vld   = r_pipe_vld[RD_LATENCY-1] & ~abort;
  assign w_exit_tag   = r_pipe_tag[RD_LATENCY-1];
  assign w_new_hdr    = {r_hi, data_i};

  always_comb begin
    w_addr_tag = c_TAG_PAY;
    if (rd_addr == 16'd0) begin
      w_addr_tag = c_TAG_HI;
    end else if (rd_addr == 16'd1) begin
      w_addr_tag = c_TAG_LO;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      new_msg   <= 1'b0;
      ram_rd_rq <= 1'b0;
      rd_addr   <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      new_msg <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        // Abort also wins over a simultaneous start in IDLE
        r_state   <= S_IDLE;
        ram_rd_rq <= 1'b0;
        rd_addr   <= 16'd0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_len   <= msg_len;
              busy    <= 1'b1;
              new_msg <= 1'b1;
              r_state <= S_NOTIFY;
            end
          end
          S_NOTIFY: begin
            ram_rd_rq <= 1'b1;
            rd_addr   <= 16'd0;
            r_state   <= S_ISSUE;
          end
          S_ISSUE: begin
            if (rd_addr == w_last_addr) begin
              ram_rd_rq <= 1'b0;
              rd_addr   <= 16'd0;
              r_state   <= S_DRAIN;
            end else begin
              rd_addr <= rd_addr + 16'd1;
            end
          end
          S_DRAIN: begin
            // done is visible for one cycle while still in DRAIN; IDLE is
            // entered on the cycle after the pulse.
            if (done) begin
              r_state <= S_IDLE;
            end else if (w_pipe_empty) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture pipeline: delays {valid, tag} by RD_LATENCY so each returned byte
  // is matched with the address that requested it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_tag[i] <= c_TAG_HI;
      end
    end else begin
      if (abort) begin
        r_pipe_vld <= '0;
      end else begin
        r_pipe_vld[0] <= ram_rd_rq;
        for (int i = 1; i < RD_LATENCY; i++) begin
          r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
      end
      r_pipe_tag[0] <= w_addr_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte capture, header reassembly and sequence check
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_hi       <= 8'd0;
      hdr_o      <= 16'd0;
      hdr_valid  <= 1'b0;
      byte_o     <= 8'd0;
      byte_valid <= 1'b0;
      r_last_hdr <= 16'd0;
      r_first    <= 1'b1;
      seq_err    <= 1'b0;
    end else begin
      hdr_valid  <= 1'b0;
      byte_valid <= 1'b0;
      if (w_exit_vld) begin
        case (w_exit_tag)
          c_TAG_HI: begin
            r_hi <= data_i;
          end
          c_TAG_LO: begin
            hdr_o     <= w_new_hdr;
            hdr_valid <= 1'b1;
            // 16-bit add wraps 16'hFFFF to 16'h0000 naturally
            if (!r_first && (w_new_hdr != (r_last_hdr + 16'd1))) begin
              seq_err <= 1'b1;
            end
            r_last_hdr <= w_new_hdr;
            r_first    <= 1'b0;
          end
          default: begin
            byte_o     <= data_i;
            byte_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_master_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_master_reader
//  Description : Self-checking bench for master_reader. A responder model
//                returns bytes after RD_LATENCY cycles. A per-cycle
//                expectation table is built from the message timing rules, and
//                literal checks pin key cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_master_reader;

  localparam int L = 2;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic        abort;
  logic [7:0]  msg_len;
  logic        new_msg;
  logic        ram_rd_rq;
  logic [15:0] rd_addr;
  logic [7:0]  data_i;
  logic [15:0] hdr_o;
  logic        hdr_valid;
  logic [7:0]  byte_o;
  logic        byte_valid;
  logic        busy;
  logic        done;
  logic        seq_err;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  master_reader #(.RD_LATENCY(L), .LEN_W(8)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .abort(abort), .msg_len(msg_len),
    .new_msg(new_msg), .ram_rd_rq(ram_rd_rq), .rd_addr(rd_addr), .data_i(data_i),
    .hdr_o(hdr_o), .hdr_valid(hdr_valid), .byte_o(byte_o), .byte_valid(byte_valid),
    .busy(busy), .done(done), .seq_err(seq_err)
  );

  // Responder: byte for an address seen at a clock edge appears L cycles later
  logic [7:0] mem [512];
  logic [7:0] dl  [L];
  always @(posedge clk) begin
    dl[0] <= ram_rd_rq ? mem[rd_addr[8:0]] : 8'h00;
    for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
  end
  assign data_i = dl[L-1];

  // Expected per-cycle outputs
  bit          e_new  [N];
  bit          e_rq   [N];
  bit          e_hv   [N];
  bit          e_bv   [N];
  bit          e_busy [N];
  bit          e_done [N];
  logic [15:0] e_addr [N];
  logic [15:0] e_hdr  [N];
  logic [7:0]  e_byte [N];

  logic [15:0] m_hdr, m_last;
  logic [7:0]  m_byte;
  bit          m_first, m_seq;
  bit          cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_new[i] = 0; e_rq[i] = 0; e_hv[i] = 0; e_bv[i] = 0;
      e_busy[i] = 0; e_done[i] = 0;
      e_addr[i] = 16'h0; e_hdr[i] = 16'h0; e_byte[i] = 8'h0;
    end
  endtask

  task automatic model_reset();
    m_hdr = 16'h0; m_last = 16'h0; m_byte = 8'h0; m_first = 1; m_seq = 0;
  endtask

  // Fill the responder memory and the expectation table for a message
  // whose start is sampled in cycle t0.
  task automatic sched(input int t0, input int len, input logic [15:0] hdr,
                       input logic [7:0] base);
    if (t0 + len + 12 >= N) begin
      $display("FAIL sched: cycle table overflow at %0d", t0);
      $fatal(1);
    end
    mem[0] = hdr[15:8];
    mem[1] = hdr[7:0];
    for (int j = 0; j < len; j++) mem[2+j] = base + 8'(j);
    e_new[t0+1] = 1;
    for (int c = t0 + 1; c <= t0 + len + 4 + L; c++) e_busy[c] = 1;
    for (int k = 0; k <= len + 1; k++) begin
      e_rq[t0+2+k]   = 1;
      e_addr[t0+2+k] = 16'(k);
    end
    e_hv[t0+4+L]  = 1;
    e_hdr[t0+4+L] = hdr;
    for (int j = 0; j < len; j++) begin
      e_bv[t0+5+j+L]   = 1;
      e_byte[t0+5+j+L] = base + 8'(j);
    end
    e_done[t0+len+5+L] = 1;
  endtask

  // Called at a falling edge; start is sampled at the next rising edge
  task automatic start_msg(input int len, input logic [15:0] hdr,
                           input logic [7:0] base, input bit hold, output int t0);
    msg_len = 8'(len);
    start   = 1'b1;
    t0      = cyc;
    sched(t0, len, hdr, base);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    if (cyc != t) begin
      n_errors++;
      $display("FAIL wait_cyc: at cycle %0d wanted %0d", cyc, t);
    end
  endtask

  task automatic run_done(input int t0, input int len);
    wait_cyc(t0 + len + 5 + L);
    chk("done_pulse", 32'(done), 32'd1);
    wait_cyc(t0 + len + 6 + L);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_new_msg"},   32'(new_msg),    32'd0);
    chk({tag, "_rd_rq"},     32'(ram_rd_rq),  32'd0);
    chk({tag, "_rd_addr"},   32'(rd_addr),    32'd0);
    chk({tag, "_hdr_o"},     32'(hdr_o),      32'd0);
    chk({tag, "_hdr_valid"}, 32'(hdr_valid),  32'd0);
    chk({tag, "_byte_o"},    32'(byte_o),     32'd0);
    chk({tag, "_byte_vld"},  32'(byte_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),       32'd0);
    chk({tag, "_done"},      32'(done),       32'd0);
    chk({tag, "_seq_err"},   32'(seq_err),    32'd0);
  endtask

  // Per-cycle compare against the expectation table
  always @(negedge clk) begin
    if (cmp_en && rst_l && cyc < N) begin
      if (e_hv[cyc]) begin
        if (!m_first && e_hdr[cyc] != m_last + 16'd1) m_seq = 1;
        m_last  = e_hdr[cyc];
        m_first = 0;
        m_hdr   = e_hdr[cyc];
      end
      if (e_bv[cyc]) m_byte = e_byte[cyc];
      chk("new_msg",    32'(new_msg),    32'(e_new[cyc]));
      chk("ram_rd_rq",  32'(ram_rd_rq),  32'(e_rq[cyc]));
      if (e_rq[cyc]) chk("rd_addr", 32'(rd_addr), 32'(e_addr[cyc]));
      chk("hdr_valid",  32'(hdr_valid),  32'(e_hv[cyc]));
      chk("hdr_o",      32'(hdr_o),      32'(m_hdr));
      chk("byte_valid", 32'(byte_valid), 32'(e_bv[cyc]));
      chk("byte_o",     32'(byte_o),     32'(m_byte));
      chk("busy",       32'(busy),       32'(e_busy[cyc]));
      chk("done",       32'(done),       32'(e_done[cyc]));
      chk("seq_err",    32'(seq_err),    32'(m_seq));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, d;
    logic [7:0] pay [3];
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
    rst_l = 1'b0; start = 1'b0; abort = 1'b0; msg_len = 8'd0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    model_reset();
    clear_from(0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_l  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Basic message: header 1234, payload A1..A3
    start_msg(3, 16'h1234, 8'hA1, 0, t0);
    for (int k = 0; k <= 4; k++) begin
      wait_cyc(t0 + 2 + k);
      chk("t1_rd_addr", 32'(rd_addr), 32'(k));
      chk("t1_rd_rq", 32'(ram_rd_rq), 32'd1);
    end
    chk("t1_hdr_valid", 32'(hdr_valid), 32'd1);
    chk("t1_hdr", 32'(hdr_o), 32'h1234);
    for (int j = 0; j < 3; j++) begin
      wait_cyc(t0 + 7 + j);
      chk("t1_byte", 32'(byte_o), 32'(pay[j]));
    end
    wait_cyc(t0 + 10);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_seq", 32'(seq_err), 32'd0);
    wait_cyc(t0 + 11);

    // Zero-length payload
    start_msg(0, 16'h1235, 8'h00, 0, t0);
    wait_cyc(t0 + 4);
    chk("t2_rq_off", 32'(ram_rd_rq), 32'd0);
    wait_cyc(t0 + 6);
    chk("t2_hdr", 32'(hdr_o), 32'h1235);
    run_done(t0, 0);

    // start while busy is ignored
    start_msg(3, 16'h1236, 8'h30, 0, t0);
    wait_cyc(t0 + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(t0 + 10);
    chk("t3_done", 32'(done), 32'd1);
    wait_cyc(t0 + 11);

    // Asynchronous reset mid-ISSUE
    start_msg(5, 16'h5555, 8'h50, 0, t0);
    wait_cyc(t0 + 4);
    #2 rst_l = 1'b0;
    #1 chk_zero("async_rst");
    clear_from(0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Wrap FFFF -> 0000 is not a gap; first header after reset never errors
    start_msg(1, 16'hFFFF, 8'h60, 0, t0);
    run_done(t0, 1);
    chk("t5_seq_a", 32'(seq_err), 32'd0);
    start_msg(2, 16'h0000, 8'h68, 0, t0);
    wait_cyc(t0 + 6);
    chk("t5_hdr", 32'(hdr_o), 32'h0000);
    run_done(t0, 2);
    chk("t5_seq_b", 32'(seq_err), 32'd0);

    // Gap 0000 -> 0005 sets seq_err; stays set through a good header
    start_msg(0, 16'h0005, 8'h00, 0, t0);
    wait_cyc(t0 + 6);
    chk("t6_seq_set", 32'(seq_err), 32'd1);
    run_done(t0, 0);
    start_msg(1, 16'h0006, 8'h06, 0, t0);
    run_done(t0, 1);
    chk("t6_seq_sticky", 32'(seq_err), 32'd1);

    // Abort in cycle 5 of a msg_len=4 message, restart in cycle 6
    start_msg(4, 16'h0007, 8'h70, 0, t0);
    wait_cyc(t0 + 5);
    abort = 1'b1;
    clear_from(cyc + 1);
    @(negedge clk);
    abort = 1'b0;
    chk("t7_rq_off", 32'(ram_rd_rq), 32'd0);
    chk("t7_busy_off", 32'(busy), 32'd0);
    chk("t7_no_hv", 32'(hdr_valid), 32'd0);
    start_msg(2, 16'h0008, 8'h80, 0, t1);
    wait_cyc(t0 + 7);
    chk("t7_restart_busy", 32'(busy), 32'd1);
    run_done(t1, 2);

    // start held high re-triggers right after done
    start_msg(1, 16'h0009, 8'h90, 1, t0);
    d = t0 + 1 + 5 + L;
    wait_cyc(d);
    chk("t8_done", 32'(done), 32'd1);
    wait_cyc(d + 1);
    msg_len = 8'd2;
    sched(d + 1, 2, 16'h000A, 8'hA0);
    @(negedge clk);
    start = 1'b0;
    chk("t8_retrigger", 32'(new_msg), 32'd1);
    run_done(d + 1, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/master_reader.md
# master_reader

Read-side initiator for the `slave_device` message interface. On a start request it notifies the responder of a new message, then walks the responder's address space: address 0 for the header high byte, address 1 for the header low byte, and addresses 2..msg_len+1 for payload bytes. It realigns the returned bytes against the responder's fixed read latency, reassembles the 16-bit header, streams payload bytes to the consumer and flags header sequence gaps.

## Interface
- `RD_LATENCY`, 2: cycles from an address on `rd_addr` (with `ram_rd_rq`=1) to the matching byte on `data_i`; legal range 1..4.
- `LEN_W`, 8: width of `msg_len`; maximum payload is 2^LEN_W−1 bytes.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_l` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `abort` in 1: synchronous; stops the current message.
- `msg_len` in LEN_W: number of payload bytes, latched when `start` is accepted.
- `new_msg` out 1: one-cycle pulse to the responder announcing a message.
- `ram_rd_rq` out 1: read request, high exactly while an address is being issued.
- `rd_addr` out 16: read address.
- `data_i` in 8: responder data (`data_o` of the slave).
- `hdr_o` out 16: reassembled header.
- `hdr_valid` out 1: one-cycle pulse when `hdr_o` is updated.
- `byte_o` out 8: payload byte.
- `byte_valid` out 1: one-cycle pulse per payload byte.
- `busy` out 1: high from start acceptance until `done`/abort completes.
- `done` out 1: one-cycle pulse at message completion.
- `seq_err` out 1: sticky; set when a header is not the previous header +1 (mod 2^16).

## Operation
- Reset value of every output is 0, including `rd_addr` and `hdr_o`. The internal `last_hdr` is cleared, and the internal `first` flag is set.
- FSM states: IDLE, NOTIFY, ISSUE, DRAIN.
  - IDLE: `start`=1 latches `msg_len`, sets `busy`, and goes to NOTIFY.
  - NOTIFY: `new_msg`=1 for this one cycle; next state is ISSUE.
  - ISSUE: drives `ram_rd_rq`=1 with `rd_addr`=0,1,…,msg_len+1, one address per cycle. After the last address it goes to DRAIN.
  - DRAIN: waits until the capture pipeline is empty, then pulses `done` and returns to IDLE.
- Capture pipeline: a shift register of depth RD_LATENCY carrying {valid, tag}.
  - Tag values: HI for addr 0, LO for addr 1, PAY for addr ≥2.
  - On pipeline exit, `data_i` is sampled into the slot selected by the tag.
  - HI stores the high byte internally.
  - LO forms `hdr_o`={hi, data_i} and pulses `hdr_valid`.
  - PAY drives `byte_o`=`data_i` and pulses `byte_valid`.
- Header check at each `hdr_valid`:
  - If `first`=0 and `hdr_o` ≠ `last_hdr`+1 (16-bit wrap: 16'hFFFF→16'h0000), set `seq_err`.
  - Then `last_hdr`←`hdr_o` and `first`←0.
  - `seq_err` clears only on reset.
- `msg_len`=0: the block issues addresses 0 and 1 only, produces a header and no payload.
- `start` while `busy` is ignored (no queueing). `start` held high in IDLE re-triggers immediately after `done`.
- `abort` (any non-IDLE state) has these effects:
  - `ram_rd_rq` drops the next cycle.
  - Pipeline valid bits are cleared, so no further `hdr_valid`/`byte_valid` pulses occur.
  - `done` is not pulsed.
  - `busy` falls the next cycle and the FSM goes to IDLE.
  - `last_hdr` is updated only if `hdr_valid` has already fired.
- `abort` together with `start` in IDLE: `abort` wins and `start` is ignored that cycle.
- Reset mid-message returns everything to reset values immediately (asynchronous).

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE.
- `new_msg`=1 and `busy`=1 in cycle 1.
- Address k (k=0..msg_len+1) is on `rd_addr` with `ram_rd_rq`=1 in cycle 2+k. `ram_rd_rq`=0 from cycle msg_len+4.
- Data for address k is sampled at the end of cycle 2+k+RD_LATENCY. The resulting `hdr_valid`/`byte_valid` is high in cycle 3+k+RD_LATENCY.
- `hdr_valid` occurs in cycle 4+RD_LATENCY.
- Payload byte j (j=0..msg_len−1) appears in cycle 5+j+RD_LATENCY, back-to-back.
- `done`=1 in cycle msg_len+5+RD_LATENCY. `busy`=0 in that same cycle. IDLE is re-entered the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `start` with msg_len=3, RD_LATENCY=2, and the responder model returning header 16'h1234 and payload A1,A2,A3 → `rd_addr` goes 0,1,2,3,4 in cycles 2–6; `hdr_o`=16'h1234 in cycle 6; `byte_o` is A1,A2,A3 in cycles 7–9; `done` in cycle 10; `seq_err`=0.
- Two messages with headers 16'hFFFF then 16'h0000 → `seq_err` stays 0. A third message with header 16'h0005 → `seq_err`=1 and stays 1 through later good messages.
- msg_len=0 → only addresses 0 and 1 are issued; `hdr_valid` in cycle 6; no `byte_valid`; `done` in cycle 7.
- `start` pulsed in cycle 4 of an active message → ignored; address sequence, outputs and `done` timing are unchanged.
- `abort` in cycle 5 of a msg_len=4 message → `ram_rd_rq`=0 from cycle 6; no `hdr_valid`/`byte_valid` after cycle 5; `done` never asserted; `busy`=0 in cycle 6; a new `start` is accepted in cycle 6.
- `rst_l` asserted mid-ISSUE → all outputs are 0 asynchronously. The next message is treated as first: no `seq_err` for any header value.
